// File: rtl/shift_unit.sv
// -----------------------------------------------------------------------------
// shift_unit
//   Datapath shift register for the CPU. A 32-bit register can be loaded
//   from one of several sources, shifted or rotated in place, cleared, or
//   held. The amount comes from a second mux.
//
// Ports
//   clk          in   clock; all state changes on posedge
//   rst          in   synchronous, active-high reset
//   sr_input_sel in   [1:0] load source: 00 reg_a, 01 reg_b, 10 {16'b0,imm16}, 11 zero
//   sr_control   in   [2:0] operation: 000 hold, 001 load, 010 sll, 011 srl,
//                           100 sra, 101 ror, 110 rol, 111 clear
//   sr_num_sel   in   [1:0] amount source: 00 reg_a[4:0], 01 shamt, 10 16, 11 0
//   reg_a        in   [DATA_W-1:0] register A (rs)
//   reg_b        in   [DATA_W-1:0] register B (rt)
//   shamt        in   [4:0] instruction shamt field
//   imm16        in   [15:0] instruction immediate
//   sr_out       out  [DATA_W-1:0] registered contents
//   sr_zero      out  high when the registered contents are zero
//   sr_loaded    out  high once a load has happened since reset or clear
// -----------------------------------------------------------------------------
module shift_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        sr_input_sel,
    input  logic [2:0]        sr_control,
    input  logic [1:0]        sr_num_sel,
    input  logic [DATA_W-1:0] reg_a,
    input  logic [DATA_W-1:0] reg_b,
    input  logic [4:0]        shamt,
    input  logic [15:0]       imm16,
    output logic [DATA_W-1:0] sr_out,
    output logic              sr_zero,
    output logic              sr_loaded
);

    localparam logic [2:0] OP_HOLD  = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_SLL   = 3'b010;
    localparam logic [2:0] OP_SRL   = 3'b011;
    localparam logic [2:0] OP_SRA   = 3'b100;
    localparam logic [2:0] OP_ROR   = 3'b101;
    localparam logic [2:0] OP_ROL   = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    logic [DATA_W-1:0]   sr_r;
    logic                loaded_r;
    logic [DATA_W-1:0]   src_s;
    logic [4:0]          amt_s;
    logic [2*DATA_W-1:0] ror_wide_s;
    logic [2*DATA_W-1:0] rol_wide_s;
    logic [DATA_W-1:0]   next_val_s;
    logic                next_loaded_s;

    // Load-source mux; the reserved code yields zero so X never reaches the register.
    always_comb begin
        src_s = {DATA_W{1'b0}};
        case (sr_input_sel)
            2'b00:   src_s = reg_a;
            2'b01:   src_s = reg_b;
            2'b10:   src_s = {{(DATA_W-16){1'b0}}, imm16};
            2'b11:   src_s = {DATA_W{1'b0}};
            default: src_s = {DATA_W{1'b0}};
        endcase
    end

    // Shift-amount mux; the reserved code yields an amount of zero.
    always_comb begin
        amt_s = 5'd0;
        case (sr_num_sel)
            2'b00:   amt_s = reg_a[4:0];
            2'b01:   amt_s = shamt;
            2'b10:   amt_s = 5'd16;
            2'b11:   amt_s = 5'd0;
            default: amt_s = 5'd0;
        endcase
    end

    // Rotates: shift a doubled copy so wrapped bits come back in, and an
    // amount of zero naturally returns the original value.
    always_comb begin
        ror_wide_s = {sr_r, sr_r} >> amt_s;
        rol_wide_s = {sr_r, sr_r} << amt_s;
    end

    // Next-state decode of the operation code.
    always_comb begin
        next_val_s    = sr_r;
        next_loaded_s = loaded_r;
        case (sr_control)
            OP_HOLD: begin
                next_val_s    = sr_r;
                next_loaded_s = loaded_r;
            end
            OP_LOAD: begin
                next_val_s    = src_s;
                next_loaded_s = 1'b1;
            end
            OP_SLL:   next_val_s = sr_r << amt_s;
            OP_SRL:   next_val_s = sr_r >> amt_s;
            OP_SRA:   next_val_s = $unsigned($signed(sr_r) >>> amt_s);
            OP_ROR:   next_val_s = ror_wide_s[DATA_W-1:0];
            OP_ROL:   next_val_s = rol_wide_s[2*DATA_W-1:DATA_W];
            OP_CLEAR: begin
                next_val_s    = {DATA_W{1'b0}};
                next_loaded_s = 1'b0;
            end
            default: begin
                next_val_s    = sr_r;
                next_loaded_s = loaded_r;
            end
        endcase
    end

    // State register; reset wins over every operation code.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_r     <= {DATA_W{1'b0}};
            loaded_r <= 1'b0;
        end else begin
            sr_r     <= next_val_s;
            loaded_r <= next_loaded_s;
        end
    end

    assign sr_out    = sr_r;
    assign sr_zero   = (sr_r == {DATA_W{1'b0}});
    assign sr_loaded = loaded_r;

endmodule

// File: tb/tb_shift_unit.sv
// -----------------------------------------------------------------------------
// tb_shift_unit
//   Self-checking bench for shift_unit: directed scenarios plus a randomized
//   run, each compared against an arithmetic reference model of the register.
// -----------------------------------------------------------------------------
module tb_shift_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  sr_input_sel;
    logic [2:0]  sr_control;
    logic [1:0]  sr_num_sel;
    logic [31:0] reg_a;
    logic [31:0] reg_b;
    logic [4:0]  shamt;
    logic [15:0] imm16;
    logic [31:0] sr_out;
    logic        sr_zero;
    logic        sr_loaded;

    int errors = 0;
    int checks = 0;

    // reference state
    logic [31:0] m_val;
    logic        m_loaded;

    shift_unit #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .sr_input_sel(sr_input_sel), .sr_control(sr_control),
        .sr_num_sel(sr_num_sel), .reg_a(reg_a), .reg_b(reg_b), .shamt(shamt),
        .imm16(imm16), .sr_out(sr_out), .sr_zero(sr_zero), .sr_loaded(sr_loaded)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_src(input logic [1:0] sel, input logic [31:0] a,
                                            input logic [31:0] b, input logic [15:0] imm);
        if (sel == 2'd0) return a;
        if (sel == 2'd1) return b;
        if (sel == 2'd2) return 32'(imm);
        return 32'd0;
    endfunction

    function automatic int ref_amt(input logic [1:0] sel, input logic [31:0] a, input logic [4:0] sh);
        if (sel == 2'd0) return int'(a % 32);
        if (sel == 2'd1) return int'(sh);
        if (sel == 2'd2) return 16;
        return 0;
    endfunction

    // Arithmetic description of each operation (multiply/divide by powers of two,
    // one-bit rotation loops) rather than a copy of the RTL expressions.
    function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] cur,
                                           input logic [31:0] src, input int amt);
        longint      s;
        logic [31:0] r;
        r = cur;
        case (op)
            3'd1: r = src;
            3'd2: r = 32'((longint'(cur) * (longint'(1) << amt)) % (longint'(1) << 32));
            3'd3: r = 32'(longint'(cur) / (longint'(1) << amt));
            3'd4: begin
                s = cur[31] ? (longint'(cur) - (longint'(1) << 32)) : longint'(cur);
                r = 32'(s >>> amt);
            end
            3'd5: for (int i = 0; i < amt; i++) r = {r[0], r[31:1]};
            3'd6: for (int i = 0; i < amt; i++) r = {r[30:0], r[31]};
            3'd7: r = 32'd0;
            default: r = cur;
        endcase
        return r;
    endfunction

    // Advance model with the inputs currently presented, then clock the DUT
    // and settle 1 time unit past the edge.
    task automatic clock_op();
        if (rst) begin
            m_val    = 32'd0;
            m_loaded = 1'b0;
        end else begin
            m_val = ref_op(sr_control, m_val, ref_src(sr_input_sel, reg_a, reg_b, imm16),
                           ref_amt(sr_num_sel, reg_a, shamt));
            if (sr_control == 3'd1) m_loaded = 1'b1;
            if (sr_control == 3'd7) m_loaded = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; sr_control = 3'd1; sr_input_sel = 2'd0; sr_num_sel = 2'd0;
        reg_a = 32'hDEAD_BEEF; reg_b = 32'h1; shamt = 5'd3; imm16 = 16'hFFFF;
        clock_op();
        clock_op();
        checks++;
        if (sr_out !== 32'd0 || sr_zero !== 1'b1 || sr_loaded !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got out=%h zero=%b loaded=%b required out=0 zero=1 loaded=0",
                     sr_out, sr_zero, sr_loaded);
        end
    endtask

    task automatic test_sll();
        rst = 1'b0; reg_b = 32'h0000_0003; shamt = 5'd4;
        sr_input_sel = 2'b01; sr_control = 3'b001;
        clock_op();
        checks++;
        if (sr_out !== 32'h3 || sr_loaded !== 1'b1) begin
            errors++;
            $display("FAIL sll_load: got out=%h loaded=%b required out=00000003 loaded=1", sr_out, sr_loaded);
        end
        sr_control = 3'b010; sr_num_sel = 2'b01;
        clock_op();
        checks++;
        if (sr_out !== 32'h30) begin
            errors++;
            $display("FAIL sll_result: got %h required 00000030", sr_out);
        end
        sr_control = 3'b000;
        for (int i = 0; i < 3; i++) begin
            reg_a = $urandom; reg_b = $urandom; shamt = 5'($urandom);
            sr_num_sel = 2'($urandom); sr_input_sel = 2'($urandom);
            clock_op();
        end
        checks++;
        if (sr_out !== 32'h30) begin
            errors++;
            $display("FAIL sll_hold: got %h required 00000030", sr_out);
        end
    endtask

    task automatic test_sra_srl();
        logic [31:0] want [2];
        logic [2:0]  ops  [2];
        want[0] = 32'hFFFF_8000; want[1] = 32'h0000_8000;
        ops[0]  = 3'b100;        ops[1]  = 3'b011;
        for (int k = 0; k < 2; k++) begin
            reg_a = 32'h8000_00F0; sr_input_sel = 2'b00; sr_control = 3'b001;
            clock_op();
            sr_control = ops[k]; sr_num_sel = 2'b00;
            clock_op();
            checks++;
            if (sr_out !== want[k]) begin
                errors++;
                $display("FAIL shift_right op=%b: got %h required %h", ops[k], sr_out, want[k]);
            end
        end
    endtask

    task automatic test_lui();
        imm16 = 16'h1234; sr_input_sel = 2'b10; sr_control = 3'b001;
        clock_op();
        sr_control = 3'b010; sr_num_sel = 2'b10;
        clock_op();
        checks++;
        if (sr_out !== 32'h1234_0000 || sr_zero !== 1'b0) begin
            errors++;
            $display("FAIL lui: got out=%h zero=%b required out=12340000 zero=0", sr_out, sr_zero);
        end
    endtask

    task automatic test_rotate();
        reg_a = 32'h8000_0001; sr_input_sel = 2'b00; sr_control = 3'b001;
        clock_op();
        shamt = 5'd1; sr_num_sel = 2'b01; sr_control = 3'b101;
        clock_op();
        checks++;
        if (sr_out !== 32'hC000_0000) begin
            errors++;
            $display("FAIL ror1: got %h required c0000000", sr_out);
        end
        sr_control = 3'b110;
        clock_op();
        checks++;
        if (sr_out !== 32'h8000_0001) begin
            errors++;
            $display("FAIL rol1: got %h required 80000001", sr_out);
        end
        shamt = 5'd0;
        clock_op();
        checks++;
        if (sr_out !== 32'h8000_0001) begin
            errors++;
            $display("FAIL rol0: got %h required 80000001", sr_out);
        end
        // reserved amount select behaves as zero for a shift
        sr_num_sel = 2'b11; sr_control = 3'b010; shamt = 5'd9;
        clock_op();
        checks++;
        if (sr_out !== 32'h8000_0001) begin
            errors++;
            $display("FAIL amt_reserved: got %h required 80000001", sr_out);
        end
    endtask

    task automatic test_reset_priority();
        reg_a = 32'hFFFF_FFFF; sr_input_sel = 2'b00; sr_control = 3'b001; rst = 1'b1;
        clock_op();
        checks++;
        if (sr_out !== 32'd0 || sr_zero !== 1'b1 || sr_loaded !== 1'b0) begin
            errors++;
            $display("FAIL rst_priority: got out=%h zero=%b loaded=%b required 0/1/0", sr_out, sr_zero, sr_loaded);
        end
        rst = 1'b0;
        clock_op();
        checks++;
        if (sr_out !== 32'hFFFF_FFFF || sr_loaded !== 1'b1) begin
            errors++;
            $display("FAIL rst_release_load: got out=%h loaded=%b required ffffffff/1", sr_out, sr_loaded);
        end
    endtask

    task automatic test_clear_hold();
        reg_b = 32'h0BAD_F00D; sr_input_sel = 2'b01; sr_control = 3'b001;
        clock_op();
        sr_control = 3'b111;
        clock_op();
        checks++;
        if (sr_out !== 32'd0 || sr_loaded !== 1'b0 || sr_zero !== 1'b1) begin
            errors++;
            $display("FAIL clear: got out=%h loaded=%b zero=%b required 0/0/1", sr_out, sr_loaded, sr_zero);
        end
        // reserved input select loads zero but still marks loaded
        sr_input_sel = 2'b11; sr_control = 3'b001; reg_a = 32'h5; reg_b = 32'h6;
        clock_op();
        checks++;
        if (sr_out !== 32'd0 || sr_loaded !== 1'b1) begin
            errors++;
            $display("FAIL src_reserved: got out=%h loaded=%b required 0/1", sr_out, sr_loaded);
        end
        reg_a = 32'h1357_9BDF; sr_input_sel = 2'b00;
        clock_op();
        sr_control = 3'b000;
        for (int i = 0; i < 4; i++) begin
            reg_a = ~reg_a; reg_b = ~reg_b; shamt = ~shamt; imm16 = ~imm16;
            sr_input_sel = ~sr_input_sel; sr_num_sel = ~sr_num_sel;
            clock_op();
        end
        checks++;
        if (sr_out !== 32'h1357_9BDF) begin
            errors++;
            $display("FAIL hold_toggle: got %h required 13579bdf", sr_out);
        end
    endtask

    task automatic test_back_to_back();
        reg_a = 32'h8000_0001; sr_input_sel = 2'b00; sr_control = 3'b001;
        clock_op();
        shamt = 5'd4; sr_num_sel = 2'b01; sr_control = 3'b110;
        clock_op();
        checks++;
        if (sr_out !== 32'h0000_0018) begin
            errors++;
            $display("FAIL b2b_rol: got %h required 00000018", sr_out);
        end
        sr_control = 3'b101;
        clock_op();
        checks++;
        if (sr_out !== 32'h8000_0001) begin
            errors++;
            $display("FAIL b2b_ror: got %h required 80000001", sr_out);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rst          = ($urandom_range(0, 19) == 0);
            sr_control   = 3'($urandom);
            sr_input_sel = 2'($urandom);
            sr_num_sel   = 2'($urandom);
            reg_a        = $urandom;
            reg_b        = $urandom;
            shamt        = 5'($urandom);
            imm16        = 16'($urandom);
            clock_op();
            checks++;
            if (sr_out !== m_val || sr_zero !== (m_val == 32'd0) || sr_loaded !== m_loaded) begin
                errors++;
                $display("FAIL random[%0d] op=%b: got out=%h zero=%b loaded=%b required out=%h zero=%b loaded=%b",
                         i, sr_control, sr_out, sr_zero, sr_loaded, m_val, (m_val == 32'd0), m_loaded);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        m_val = 32'd0; m_loaded = 1'b0;
        test_reset();
        test_sll();
        test_sra_srl();
        test_lui();
        test_rotate();
        test_reset_priority();
        test_clear_hold();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
